// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file arbiter.
package regfile_arb_pkg;

   // Number of requesters sharing the register file.
   localparam int unsigned NumReq = 2;

   // Default widths of the register file.
   localparam int unsigned DefAddrWidth = 4;
   localparam int unsigned DefDataWidth = 32;

   // Controller states; one operation in flight at most.
   typedef enum logic [2:0] {
      StInit,
      StIdle,
      StIssue,
      StCapture,
      StResp
   } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. The pointer remembers the last winner and only
// moves when the caller signals that the grant was consumed.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   // 1 when requester 1 won last; reset to 1 so requester 0 goes first.
   logic last_q;

   // Grant the single requester, or the one that did not win last time.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Move the pointer only when a grant is actually taken.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_q <= 1'b1;
      end else if (advance && (grant != 2'b00)) begin
         last_q <= grant[1];
      end
   end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto a register file with registered read data.
// Writes take IDLE+ISSUE; reads go IDLE, ISSUE, CAPTURE, then hold in RESP.
module regfile_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = DefAddrWidth,
   parameter int unsigned DATA_WIDTH = DefDataWidth
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NumReq-1:0]            req_valid,
   output logic [NumReq-1:0]            req_ready,
   input  logic [NumReq-1:0]            req_write,
   input  logic [NumReq*ADDR_WIDTH-1:0] req_addr_a,
   input  logic [NumReq*ADDR_WIDTH-1:0] req_addr_b,
   input  logic [NumReq*DATA_WIDTH-1:0] req_wdata,
   output logic [NumReq-1:0]            rsp_valid,
   input  logic [NumReq-1:0]            rsp_ready,
   output logic [DATA_WIDTH-1:0]        rsp_data_a,
   output logic [DATA_WIDTH-1:0]        rsp_data_b,
   output logic                         rf_reset,
   output logic                         rf_write,
   output logic [ADDR_WIDTH-1:0]        rf_write_addr,
   output logic [DATA_WIDTH-1:0]        rf_write_data,
   output logic [ADDR_WIDTH-1:0]        rf_read_addr_a,
   output logic [ADDR_WIDTH-1:0]        rf_read_addr_b,
   input  logic [DATA_WIDTH-1:0]        rf_read_data_a,
   input  logic [DATA_WIDTH-1:0]        rf_read_data_b
);

   state_e state_q, state_d;

   logic [NumReq-1:0]     grant;
   logic                  accept;
   logic                  sel;

   logic                  wr_q;
   logic                  idx_q;
   logic [ADDR_WIDTH-1:0] addr_a_q;
   logic [ADDR_WIDTH-1:0] addr_b_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rsp_a_q;
   logic [DATA_WIDTH-1:0] rsp_b_q;

   rr_arbiter2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req_valid),
      .advance (accept),
      .grant   (grant)
   );

   assign accept = (state_q == StIdle) && (grant != '0);
   assign sel    = grant[1];

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         StInit:    state_d = StIdle;
         StIdle:    if (accept) state_d = StIssue;
         StIssue:   state_d = wr_q ? StIdle : StCapture;
         StCapture: state_d = StResp;
         StResp:    if (rsp_ready[idx_q]) state_d = StIdle;
         default:   state_d = StInit;
      endcase
   end

   // Latch the winning request; requests are only looked at in IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_q     <= 1'b0;
         idx_q    <= 1'b0;
         addr_a_q <= '0;
         addr_b_q <= '0;
         wdata_q  <= '0;
      end else if (accept) begin
         wr_q     <= req_write[sel];
         idx_q    <= sel;
         addr_a_q <= sel ? req_addr_a[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_a[ADDR_WIDTH-1:0];
         addr_b_q <= sel ? req_addr_b[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_b[ADDR_WIDTH-1:0];
         wdata_q  <= sel ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
      end
   end

   // Capture the file's registered read data at the end of CAPTURE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_a_q <= '0;
         rsp_b_q <= '0;
      end else if (state_q == StCapture) begin
         rsp_a_q <= rf_read_data_a;
         rsp_b_q <= rf_read_data_b;
      end
   end

   // Handshake and register-file strobes decoded from the current state.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      rf_reset  = 1'b0;
      rf_write  = 1'b0;
      case (state_q)
         StInit:  rf_reset = 1'b1;
         StIdle:  req_ready = grant;
         StIssue: rf_write = wr_q;
         StResp:  rsp_valid[idx_q] = 1'b1;
         default: ;
      endcase
   end

   // Address 0 writes are passed through untouched; the file drops them.
   assign rf_write_addr  = addr_a_q;
   assign rf_write_data  = wdata_q;
   assign rf_read_addr_a = addr_a_q;
   assign rf_read_addr_b = addr_b_q;
   assign rsp_data_a     = rsp_a_q;
   assign rsp_data_b     = rsp_b_q;

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 4, meaning register address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning register data width.
REQ-003 The block SHALL have the following ports, one per line as name, direction, width, meaning:
- clk  in  1  single clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester request valid.
- req_ready  out  2  per-requester request accept, one-hot or zero.
- req_write  in  2  per-requester op select: 1 = write, 0 = read.
- req_addr_a  in  2xADDR_WIDTH  write address, or read address for bus A.
- req_addr_b  in  2xADDR_WIDTH  read address for bus B.
- req_wdata  in  2xDATA_WIDTH  write data.
- rsp_valid  out  2  per-requester read response valid.
- rsp_ready  in  2  per-requester response accept.
- rsp_data_a  out  DATA_WIDTH  read result, bus A.
- rsp_data_b  out  DATA_WIDTH  read result, bus B.
- rf_reset  out  1  synchronous clear to the register file.
- rf_write  out  1  register file write enable.
- rf_write_addr  out  ADDR_WIDTH  register file write address.
- rf_write_data  out  DATA_WIDTH  register file write data.
- rf_read_addr_a  out  ADDR_WIDTH  register file read address, bus A.
- rf_read_addr_b  out  ADDR_WIDTH  register file read address, bus B.
- rf_read_data_a  in  DATA_WIDTH  registered read data from the file, bus A.
- rf_read_data_b  in  DATA_WIDTH  registered read data from the file, bus B.

Function
REQ-004 The controller SHALL have states INIT, IDLE, ISSUE, CAPTURE and RESP, with at most one operation outstanding.
REQ-005 INIT SHALL last exactly one cycle with rf_reset=1 and rf_write=0, then go to IDLE.
REQ-006 In IDLE, req_ready SHALL be asserted combinationally to the single granted requester with req_valid=1; it SHALL be 0 in all other states.
REQ-007 Arbitration SHALL be round-robin:
- when both requesters are valid, the one not granted last wins;
- after reset, requester 0 has priority;
- the pointer updates only on acceptance.
REQ-008 On acceptance, the op, addresses, data and requester index SHALL be latched, and the FSM SHALL go to ISSUE.
REQ-009 In ISSUE, the rf_* address/data outputs SHALL be driven from the latched values; rf_write SHALL equal the latched write bit, and rf_reset SHALL be 0.
REQ-010 A write SHALL complete in ISSUE, return to IDLE and produce no response; total occupancy is 2 cycles.
REQ-011 Writes to address 0 SHALL be forwarded unchanged; the register file ignores them.
REQ-012 A read SHALL go ISSUE -> CAPTURE, holding the read addresses and rf_write=0 in CAPTURE.
REQ-013 At the end of CAPTURE, rf_read_data_a/b SHALL be registered into rsp_data_a/b, and the FSM SHALL enter RESP.
REQ-014 In RESP, rsp_valid SHALL be asserted only for the latched requester, with rsp_data stable, until rsp_ready for that requester.
REQ-015 When rsp_ready is seen in RESP, the FSM SHALL return to IDLE; a new request may be accepted in the following cycle.
REQ-016 Read latency SHALL be 3 cycles from the acceptance edge to rsp_valid high, independent of rsp_ready.
REQ-017 Outside ISSUE and CAPTURE, rf_write SHALL be 0.
REQ-018 rsp_ready for a non-owning requester SHALL be ignored.
REQ-019 req_* inputs SHALL be ignored while not in IDLE.

Reset
REQ-020 Asserting reset_n low SHALL immediately force:
- state to INIT;
- req_ready=0, rsp_valid=0, rf_write=0;
- rsp_data_a/b, rf addresses and rf_write_data to 0;
- the round-robin pointer to favour requester 0.
REQ-021 Reset during an operation SHALL discard it without a response; the first cycle after release SHALL be INIT with rf_reset=1.

Structure
REQ-022 A package regfile_arb_pkg SHALL hold the state enum, requester count (2) and default width constants.
REQ-023 Arbitration SHALL live in sub-module rr_arbiter2, which takes a 2-bit request and an advance strobe and returns a one-hot grant.

Verification
REQ-024 Reset release -> rf_reset=1 for exactly one cycle, then IDLE with req_ready following req_valid.
REQ-025 Requester 0 writes addr 5 = 0xDEADBEEF, then reads a=5, b=0 -> rsp_valid[0] 3 cycles after acceptance, rsp_data_a=0xDEADBEEF, rsp_data_b=0.
REQ-026 Both requesters valid continuously for 4 operations -> grants alternate 0,1,0,1.
REQ-027 Read response with rsp_ready=0 for 5 cycles -> rsp_valid and data held, no new req_ready; rsp_ready[1] while owner is 0 -> no effect.
REQ-028 Write addr 0 = 0x1234, then read a=0 -> rsp_data_a=0.
REQ-029 reset_n low while in CAPTURE -> outputs zero immediately, no rsp_valid, INIT on release.
